// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA display timing generator.
//   Steps one pixel position for each clk that has pix_en=1. Every output is
//   registered from the same (hc,vc) decode, so all outputs describe the
//   position consumed on the previous pix_en clk.
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high; takes priority over pix_en
//   pix_en       pixel-rate enable
//   horiz_sync   horizontal sync, asserted level = SYNC_POL
//   vert_sync    vertical sync, asserted level = SYNC_POL
//   video_on     1 inside the visible area
//   pixel_column horizontal position, 0..H_TOTAL-1 (raw, also during blanking)
//   pixel_row    vertical position, 0..V_TOTAL-1 (raw, also during blanking)
//   frame_start  one-clk pulse on the load that presents (0,0)
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       video_on,
  output logic [9:0] pixel_column,
  output logic [9:0] pixel_row,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_ON  = (SYNC_POL != 0);

  logic [9:0] hc, vc;
  logic       hs_hit, vs_hit, vis;

  assign hs_hit = (hc >= HS_FIRST) && (hc <= HS_LAST);
  assign vs_hit = (vc >= VS_FIRST) && (vc <= VS_LAST);
  assign vis    = (hc < H_VIS) && (vc < V_VIS);

  always_ff @(posedge clk) begin
    if (reset) begin
      hc           <= '0;
      vc           <= '0;
      pixel_column <= '0;
      pixel_row    <= '0;
      video_on     <= 1'b0;
      frame_start  <= 1'b0;
      horiz_sync   <= ~SYNC_ON;
      vert_sync    <= ~SYNC_ON;
    end else if (pix_en) begin
      // Load the decode of the position being consumed, then advance.
      pixel_column <= hc;
      pixel_row    <= vc;
      video_on     <= vis;
      horiz_sync   <= hs_hit ? SYNC_ON : ~SYNC_ON;
      vert_sync    <= vs_hit ? SYNC_ON : ~SYNC_ON;
      frame_start  <= (hc == '0) && (vc == '0);
      if (hc < H_LAST) begin
        hc <= hc + 10'd1;
      end else begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
      end
    end else begin
      // Idle clk: everything holds, but the frame pulse lasts one clk only.
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Two instances share one stimulus
// stream: dut0 uses the 640x480 defaults, dut1 a tiny 12x7 raster with
// active-high syncs so frame wraps and vertical sync are reached quickly.
// Expected outputs come from the strobe count since reset: position =
// count mod frame size, column/row by division.
module tb_vga_timing_gen;

  typedef struct {
    logic [9:0]  col;
    logic [9:0]  row;
    logic        von;
    logic        hs;
    logic        vs;
    logic        fs;
    int unsigned n;
  } exp_t;

  bit   clk;
  logic reset, pix_en;
  logic hs0, vs0, von0, fs0, hs1, vs1, von1, fs1;
  logic [9:0] col0, row0, col1, row1;

  always #5 clk = ~clk;

  vga_timing_gen dut0 (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .horiz_sync(hs0), .vert_sync(vs0), .video_on(von0),
    .pixel_column(col0), .pixel_row(row0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)
  ) dut1 (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .horiz_sync(hs1), .vert_sync(vs1), .video_on(von1),
    .pixel_column(col1), .pixel_row(row1), .frame_start(fs1)
  );

  int checks = 0;
  int failures = 0;
  int unsigned n = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t hold[2];
  int hs_cnt, von_cnt;
  int unsigned fs_prev;
  bit fs_prev_ok;
  logic last_en = 1'b0;
  logic last_rst = 1'b1;

  // Reference: timing from the raster description, not from counters.
  function automatic exp_t model(int unsigned k, bit sm);
    exp_t e;
    int ha, hf, hw, hb, va, vf, vw, vb, ht, vt, p, c, r;
    bit pol;
    if (sm) begin
      ha = 8; hf = 1; hw = 2; hb = 1; va = 4; vf = 1; vw = 1; vb = 1; pol = 1;
    end else begin
      ha = 640; hf = 16; hw = 96; hb = 48; va = 480; vf = 10; vw = 2; vb = 33; pol = 0;
    end
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    p  = int'(k % (ht * vt));
    c  = p % ht;
    r  = p / ht;
    e.col = 10'(c);
    e.row = 10'(r);
    e.von = (c < ha) && (r < va);
    e.hs  = (c >= ha + hf && c < ha + hf + hw) ? pol : !pol;
    e.vs  = (r >= va + vf && r < va + vf + vw) ? pol : !pol;
    e.fs  = (p == 0);
    e.n   = k;
    return e;
  endfunction

  function automatic exp_t rst_val(int d);
    exp_t e;
    e.col = '0; e.row = '0; e.von = 1'b0; e.fs = 1'b0; e.n = 0;
    e.hs  = (d == 1) ? 1'b0 : 1'b1;
    e.vs  = e.hs;
    return e;
  endfunction

  function automatic exp_t get_act(int d);
    exp_t a;
    a.n = 0;
    if (d == 0) begin
      a.col = col0; a.row = row0; a.von = von0; a.hs = hs0; a.vs = vs0; a.fs = fs0;
    end else begin
      a.col = col1; a.row = row1; a.von = von1; a.hs = hs1; a.vs = vs1; a.fs = fs1;
    end
    return a;
  endfunction

  task automatic cmp(string nm, int d, exp_t a, exp_t e);
    checks++;
    if (a.col !== e.col || a.row !== e.row || a.von !== e.von ||
        a.hs !== e.hs || a.vs !== e.vs || a.fs !== e.fs) begin
      failures++;
      $display("FAIL %s dut%0d strobe=%0d got col=%0d row=%0d von=%b hs=%b vs=%b fs=%b exp col=%0d row=%0d von=%b hs=%b vs=%b fs=%b",
               nm, d, e.n, a.col, a.row, a.von, a.hs, a.vs, a.fs,
               e.col, e.row, e.von, e.hs, e.vs, e.fs);
    end
  endtask

  task automatic check_int(string nm, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, want);
    end
  endtask

  always @(posedge clk) begin
    last_en  <= pix_en;
    last_rst <= reset;
  end

  // Monitor: outputs are checked every clk against what the last edge implies.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e, a;
      int qs;
      a  = get_act(d);
      qs = (d == 0) ? q0.size() : q1.size();
      if (last_rst) begin
        e = rst_val(d);
        cmp("reset", d, a, e);
        hold[d] = e;
        if (d == 1) fs_prev_ok = 1'b0;
      end else if (last_en) begin
        if (qs == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow dut%0d got=empty exp=entry", d);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          cmp("strobe", d, a, e);
          hold[d]    = e;
          hold[d].fs = 1'b0;
          if (d == 0 && a.hs === 1'b0) hs_cnt++;
          if (d == 0 && a.von === 1'b1) von_cnt++;
          if (d == 1 && a.fs === 1'b1) begin
            if (fs_prev_ok) check_int("frame_period", int'(e.n - fs_prev), 84);
            fs_prev    = e.n;
            fs_prev_ok = 1'b1;
          end
        end
      end else begin
        cmp("hold", d, a, hold[d]);
      end
    end
  end

  task automatic step(bit en, bit rst);
    reset  = rst;
    pix_en = en;
    if (rst) begin
      n = 0;
    end else if (en) begin
      q0.push_back(model(n, 1'b0));
      q1.push_back(model(n, 1'b1));
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    pix_en = 1'b0;
    repeat (2) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);

    // One full line at a quarter of the clk rate.
    hs_cnt  = 0;
    von_cnt = 0;
    repeat (800) begin
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
    check_int("hsync_width_line0", hs_cnt, 96);
    check_int("video_on_line0", von_cnt, 640);

    // Random enable pattern, crossing several line wraps on dut0 and
    // many frame wraps on dut1.
    repeat (20000) step(($urandom % 4) != 0, 1'b0);

    // Reset mid-frame with pix_en high in the same clk.
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    repeat (4000) step(1'b1, 1'b0);

    // Reset released straight into a strobe.
    step(1'b1, 1'b1);
    repeat (2000) step(($urandom % 2) != 0, 1'b0);
    repeat (3) step(1'b0, 1'b0);

    check_int("scoreboard_drained_dut0", q0.size(), 0);
    check_int("scoreboard_drained_dut1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
